// File: rtl/keypad_digit_ctrl_pkg.sv
// Shared types and constants for the keypad digit controller.
// Key FSM states, display mux states and digit-enable encodings.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } key_state_t;

  typedef enum logic [1:0] {
    BLANK_LR,
    SHOW_R,
    BLANK_RL,
    SHOW_L
  } mux_state_t;

  localparam logic [1:0] AN_RIGHT = 2'b10;
  localparam logic [1:0] AN_LEFT  = 2'b01;
  localparam logic [1:0] AN_OFF   = 2'b11;

  function automatic logic [1:0] an_decode(mux_state_t s);
    logic [1:0] an;
    an = AN_OFF;
    unique case (s)
      SHOW_R:   an = AN_RIGHT;
      SHOW_L:   an = AN_LEFT;
      BLANK_LR: an = AN_OFF;
      BLANK_RL: an = AN_OFF;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/keypad_digit_ctrl_if.sv
// Scanner-side key inputs and display-side outputs
// of the keypad digit controller.
interface keypad_digit_ctrl_if;
  logic       key_down;
  logic [3:0] key_code;
  logic       new_key;
  logic [3:0] latest;
  logic [3:0] previous;
  logic [3:0] digit;
  logic [1:0] an_l;

  modport master (
    output key_down,
    output key_code,
    input  new_key,
    input  latest,
    input  previous,
    input  digit,
    input  an_l
  );

  modport slave (
    input  key_down,
    input  key_code,
    output new_key,
    output latest,
    output previous,
    output digit,
    output an_l
  );
endinterface

// File: rtl/keypad_digit_ctrl_digit_mux_sched.sv
// Time-multiplexes one seven-segment decoder across two digits
// with blanking dead-time between digit swaps.
module digit_mux_sched
  import keypad_pkg::*;
#(
  parameter int MUX_CYCLES   = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] latest,
  input  logic [3:0] previous,
  output logic [3:0] digit,
  output logic [1:0] an_l
);

  localparam int MAXC =
    (MUX_CYCLES > BLANK_CYCLES) ? MUX_CYCLES : BLANK_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  mux_state_t    r_state;
  mux_state_t    w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic [CW-1:0] w_lim;
  logic          w_show;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= BLANK_LR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt + CW'(1);
    w_show = (r_state == SHOW_R) || (r_state == SHOW_L);
    w_lim  = w_show ? CW'(MUX_CYCLES - 1) : CW'(BLANK_CYCLES - 1);
    if (r_cnt == w_lim) begin
      w_cnt = '0;
      unique case (r_state)
        BLANK_LR: w_next = SHOW_R;
        SHOW_R:   w_next = BLANK_RL;
        BLANK_RL: w_next = SHOW_L;
        SHOW_L:   w_next = BLANK_LR;
      endcase
    end
  end

  // Decoder input switches at blank entry so it settles before enable.
  always_comb begin
    an_l  = an_decode(r_state);
    digit = previous;
    if ((r_state == BLANK_LR) || (r_state == SHOW_R))
      digit = latest;
  end

endmodule

// File: rtl/keypad_digit_ctrl.sv
// Debounces scanner key presses, keeps a two-key history and
// drives the shared dual-digit seven-segment display.
module keypad_digit_ctrl
  import keypad_pkg::*;
#(
  parameter int DB_CYCLES    = 20,
  parameter int MUX_CYCLES   = 8,
  parameter int BLANK_CYCLES = 2
) (
  input logic               clk,
  input logic               nrst,
  keypad_digit_ctrl_if.slave bus
);

  localparam int DBW = $clog2(DB_CYCLES);

  key_state_t     r_state;
  key_state_t     w_next;
  logic [3:0]     r_cand;
  logic [3:0]     w_cand;
  logic [DBW-1:0] r_cnt;
  logic [DBW-1:0] w_cnt;
  logic           r_new_key;
  logic           w_new_key;
  logic [3:0]     r_latest;
  logic [3:0]     w_latest;
  logic [3:0]     r_previous;
  logic [3:0]     w_previous;
  logic           w_last;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state    <= IDLE;
      r_cand     <= '0;
      r_cnt      <= '0;
      r_new_key  <= 1'b0;
      r_latest   <= '0;
      r_previous <= '0;
    end else begin
      r_state    <= w_next;
      r_cand     <= w_cand;
      r_cnt      <= w_cnt;
      r_new_key  <= w_new_key;
      r_latest   <= w_latest;
      r_previous <= w_previous;
    end
  end

  // One counter serves both debounce and release; cleared on entry.
  always_comb begin
    w_next     = r_state;
    w_cand     = r_cand;
    w_cnt      = r_cnt;
    w_new_key  = 1'b0;
    w_latest   = r_latest;
    w_previous = r_previous;
    w_last     = (r_cnt == DBW'(DB_CYCLES - 1));
    unique case (r_state)
      IDLE: begin
        if (bus.key_down) begin
          w_next = DEBOUNCE;
          w_cand = bus.key_code;
          w_cnt  = '0;
        end
      end
      DEBOUNCE: begin
        if (!bus.key_down || (bus.key_code != r_cand)) begin
          w_next = IDLE;
        end else if (w_last) begin
          w_next     = HELD;
          w_previous = r_latest;
          w_latest   = r_cand;
          w_new_key  = 1'b1;
        end else begin
          w_cnt = r_cnt + DBW'(1);
        end
      end
      HELD: begin
        if (!bus.key_down) begin
          w_next = RELEASE;
          w_cnt  = '0;
        end
      end
      RELEASE: begin
        if (bus.key_down) begin
          w_next = HELD;
        end else if (w_last) begin
          w_next = IDLE;
        end else begin
          w_cnt = r_cnt + DBW'(1);
        end
      end
    endcase
  end

  assign bus.new_key  = r_new_key;
  assign bus.latest   = r_latest;
  assign bus.previous = r_previous;

  digit_mux_sched #(
    .MUX_CYCLES   (MUX_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_mux (
    .clk      (clk),
    .nrst     (nrst),
    .latest   (r_latest),
    .previous (r_previous),
    .digit    (bus.digit),
    .an_l     (bus.an_l)
  );

endmodule
